// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-word addition sequencer feeding an external W-bit adder stage
// Operands are issued LSW first; each word's carry-out feeds the next word's carry-in.
module wide_add_seq #(
    parameter int W       = 64,
    parameter int NWORDS  = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W*NWORDS-1:0]   in_a,
    input  logic [W*NWORDS-1:0]   in_b,
    input  logic                  in_cin,
    output logic [W-1:0]          add_a,
    output logic [W-1:0]          add_b,
    output logic                  add_cin,
    output logic                  add_issue,
    input  logic [W-1:0]          add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W*NWORDS-1:0]   out_sum,
    output logic                  out_cout
);

    localparam int TW   = W * NWORDS;
    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
    localparam logic [3:0]      CNT_INIT = (ADD_LAT > 0) ? 4'(ADD_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   a_q, a_d;
    logic [TW-1:0]   b_q, b_d;
    logic [TW-1:0]   sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Adder drive is combinational from state so an ADD_LAT=0 adder can be sampled in ISSUE.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        add_issue = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                add_a     = a_q[int'(idx_q)*W +: W];
                add_b     = b_q[int'(idx_q)*W +: W];
                add_cin   = carry_q;
                add_issue = 1'b1;
                if (ADD_LAT == 0) begin
                    capture = 1'b1;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // add_sum/add_cout are only trusted here; stale pipeline contents never reach the result.
        if (capture) begin
            sum_d[int'(idx_q)*W +: W] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
                cout_d  = add_cout;
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ISSUE;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
